instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the CPU decode/execute core; it produces the IR/PC pair that the core consumes.
- Holds the fetch PC and issues byte-wide reads to instruction memory over a request/ready handshake.
- Buffers returned instructions in a small prefetch FIFO and presents them to the core with a valid/ready handshake.
- Supports branch redirect, with flush of buffered and in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: byte-wide fetch over req/ready, prefetch FIFO, IR/PC valid/ready to the core.
// Define FETCH_PERF_EN to add the stall_cnt output (cycles with no instruction presented).
module instr_fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [7:0] ir_out,
  output logic [7:0] pc_out,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  // Handshakes: a memory read completes in any cycle with mem_req & mem_ready
  // (mem_addr held until then); the core takes the head when ir_valid & ir_ready.
  // A redirect in the same cycle cancels the memory write but not the core read.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // state is the probe point for FSM checkers
  state_t state;
  state_t state_next;

  logic [7:0]    fetch_pc;
  logic [15:0]   fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_en;
  logic          rd_en;

  assign rd_en = ir_valid & ir_ready;
  assign wr_en = mem_req & mem_ready & ~redirect_valid;

  always_comb begin
    count_next = count;
    if (redirect_valid) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request only while the FIFO will have room after this cycle's read/write.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = REQ;
    end else begin
      case (state)
        IDLE:    if (count_next < FULL) state_next = REQ;
        REQ:     if (count_next >= FULL) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = 1'b0;
    case (state)
      REQ:     mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  assign mem_addr = fetch_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (wr_en) begin
          fifo_mem[wr_ptr] <= {mem_rdata, fetch_pc};
          wr_ptr           <= wr_ptr + 1'b1;
          fetch_pc         <= fetch_pc + 8'd1;
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign ir_valid = (count != '0);
  assign ir_out   = fifo_mem[rd_ptr][15:8];
  assign pc_out   = fifo_mem[rd_ptr][7:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (!ir_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based fetch model.
module tb_instr_fetch_unit;

  localparam int         DEPTH    = 2;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       ir_valid;
  logic       ir_ready;
  logic [7:0] ir_out;
  logic [7:0] pc_out;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] imem [256];
  assign mem_rdata = imem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: buffered {ir, pc} pairs, fetch address, request permission, stall count
  logic [15:0] exp_q[$];
  logic [7:0]  m_pc;
  logic        m_req;
  logic [15:0] m_stall;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .ir_out(ir_out),
    .pc_out(pc_out),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Consume n instructions starting at first_pc (wrapping), checking order and content.
  task automatic collect(input int n, input logic [7:0] first_pc, input string tag);
    int got;
    logic [7:0] p;
    got = 0;
    for (int k = 0; k < 60 && got < n; k++) begin
      if (ir_valid && ir_ready) begin
        p = first_pc + 8'(got);
        chk({tag, "_pc"}, pc_out, p);
        chk({tag, "_ir"}, ir_out, imem[p]);
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_count"}, got, n);
  endtask

  // Reference model: advances at each clock edge from the inputs and its own state.
  initial begin
    bit rd;
    bit wr;
    exp_q.delete();
    m_pc    = RESET_PC;
    m_req   = 1'b0;
    m_stall = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        m_pc    = RESET_PC;
        m_req   = 1'b0;
        m_stall = '0;
      end else begin
        if (exp_q.size() == 0 && m_stall != 16'hFFFF) m_stall++;
        rd = (exp_q.size() != 0) && ir_ready;
        wr = m_req && mem_ready;
        if (redirect_valid) begin
          exp_q.delete();
          m_pc = redirect_pc;
        end else begin
          if (rd) void'(exp_q.pop_front());
          if (wr) begin
            exp_q.push_back({imem[m_pc], m_pc});
            m_pc++;
          end
        end
        m_req = (exp_q.size() < DEPTH);
      end
    end
  end

  // Scoreboard compare, every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("model_mem_req", mem_req, m_req);
        chk("model_mem_addr", mem_addr, m_pc);
        chk("model_ir_valid", ir_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("model_ir_out", ir_out, exp_q[0][15:8]);
          chk("model_pc_out", pc_out, exp_q[0][7:0]);
        end
`ifdef FETCH_PERF_EN
        chk("model_stall_cnt", stall_cnt, m_stall);
`endif
      end
    end
  end

  // driver
  initial begin
    int n_txn;
    int n_del;
    int last_del;
    int wcnt;
    logic [7:0] txn_addr [8];
    logic [7:0] held;

    reset          = 1'b0;
    mem_ready      = 1'b0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'(i + 16);

    // reset values
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_out", ir_out, 0);
    chk("rst_pc_out", pc_out, 0);

    // zero-wait fetch
    mem_ready = 1'b1;
    ir_ready  = 1'b1;
    do_reset();
    @(negedge clk);
    chk("zw_valid_cycle1", ir_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zw_valid", ir_valid, 1);
      chk("zw_pc", pc_out, 8'(i));
      chk("zw_ir", ir_out, 8'(8'h10 + i));
    end

    // backpressure
    ir_ready = 1'b0;
    do_reset();
    n_txn = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (mem_req && mem_ready && n_txn < 8) begin
        txn_addr[n_txn] = mem_addr;
        n_txn++;
      end
      if (i >= 2) begin
        chk("bp_head_valid", ir_valid, 1);
        chk("bp_head_pc", pc_out, 8'h00);
        chk("bp_head_ir", ir_out, 8'h10);
      end
    end
    chk("bp_txn_count", n_txn, 2);
    chk("bp_txn_addr0", txn_addr[0], 8'h00);
    chk("bp_txn_addr1", txn_addr[1], 8'h01);
    chk("bp_req_dropped", mem_req, 0);
    ir_ready = 1'b1;
    collect(5, 8'h00, "bp_drain");

    // wait states: three wait cycles per access
    mem_ready = 1'b0;
    ir_ready  = 1'b1;
    do_reset();
    wcnt     = 0;
    n_del    = 0;
    last_del = 0;
    held     = 8'h00;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        chk("ws_pc", pc_out, 8'(n_del));
        if (n_del > 0) chk("ws_interval", i - last_del, 4);
        last_del = i;
        n_del++;
      end
      if (mem_req) begin
        if (wcnt == 0) held = mem_addr;
        else chk("ws_addr_hold", mem_addr, held);
        if (wcnt == 3) begin
          mem_ready = 1'b1;
          wcnt      = 0;
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
    chk("ws_deliveries", n_del >= 4, 1);

    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);

    // redirect with a request stalled at address 3
    mem_ready = 1'b1;
    ir_ready  = 1'b1;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h03) break;
    end
    mem_ready = 1'b0;
    ir_ready  = 1'b0;
    @(negedge clk);
    chk("rd_pre_req", mem_req, 1);
    chk("rd_pre_addr", mem_addr, 8'h03);
    chk("rd_pre_valid", ir_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd_flush_valid", ir_valid, 0);
    chk("rd_new_addr", mem_addr, 8'h40);
    chk("rd_new_req", mem_req, 1);
    mem_ready = 1'b1;
    ir_ready  = 1'b1;
    collect(3, 8'h40, "rd_after");

    // pc wrap
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("wrap_flush_valid", ir_valid, 0);
    collect(4, 8'hFE, "wrap");

    // back-to-back redirects: the last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    @(negedge clk);
    redirect_pc = 8'h90;
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(3, 8'h90, "dbl");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      mem_ready      = ($urandom_range(0, 3) != 0);
      ir_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 8'($urandom);
    end
    @(negedge clk);
    redirect_valid = 1'b0;

`ifdef FETCH_PERF_EN
    // starve the core long enough to saturate the counter
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    mem_ready      = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (65600) @(negedge clk);
    chk("perf_saturated", stall_cnt, 16'hFFFF);
`endif

    // asynchronous reset while the FIFO is full
    mem_ready = 1'b1;
    ir_ready  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ir_valid && !mem_req) break;
    end
    chk("ar_full_valid", ir_valid, 1);
    chk("ar_full_req", mem_req, 0);
    mem_ready = 1'b1;
    ir_ready  = 1'b1;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_req_drop", mem_req, 0);
    chk("ar_valid_drop", ir_valid, 0);
    chk("ar_addr_reset", mem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    chk("ar_stall_clear", stall_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    collect(3, RESET_PC, "ar_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
